// File: rtl/jedro_1_core.sv
//------------------------------------------------------------------------------
// jedro_1_core: minimal multi-cycle RV32I-subset core (no pipeline).
//
// Each instruction walks FETCH -> EXEC (-> LOAD_WB for LW) -> FETCH.
// The instruction ROM and the data RAM are synchronous: read data arrives one
// cycle after the enable/address is presented.
//
// Supported: LUI, AUIPC, OP-IMM, OP, JAL, JALR, branches, LW, SW.
// Anything else, including illegal funct fields, retires as a NOP.
//
// Parameters
//   DATA_WIDTH  data/instruction width (only 32 supported)
//   ADDR_WIDTH  byte-address width of both memory ports
//   BOOT_ADDR   PC after reset
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         synchronous reset, active high
//   imem_en_o     instruction read enable (FETCH only)
//   imem_addr_o   instruction byte address (= PC during FETCH, else 0)
//   imem_rdata_i  instruction word, valid the cycle after FETCH
//   dmem_en_o     data access enable (EXEC of LW/SW only)
//   dmem_we_o     byte write enables, 4'hF for SW, 0 for LW
//   dmem_addr_o   data byte address rs1 + imm, low bits passed through
//   dmem_wdata_o  store data (rs2) for SW, 0 otherwise
//   dmem_rdata_i  load data, valid in LOAD_WB
//
// Sub-module jedro_1_regfile (instance regfile_inst) holds regfile[0:31].
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module jedro_1_regfile #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [4:0]            waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [4:0]            raddr_a,
    input  logic [4:0]            raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic [DATA_WIDTH-1:0] rdata_b
);

    logic [DATA_WIDTH-1:0] regfile [0:31];

    // Register storage: cleared on reset, x0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regfile[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (we && (waddr != 5'd0)) begin
            regfile[waddr] <= wdata;
        end
    end

    // Reads are asynchronous, so they see the value before this cycle's write.
    assign rdata_a = (raddr_a == 5'd0) ? {DATA_WIDTH{1'b0}} : regfile[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? {DATA_WIDTH{1'b0}} : regfile[raddr_b];

endmodule

module jedro_1_core #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  imem_en_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  dmem_en_o,
    output logic [3:0]            dmem_we_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_EXEC    = 2'd1,
        ST_LOAD_WB = 2'd2
    } state_t;

    state_t                state_r, state_next_s;
    logic [ADDR_WIDTH-1:0] pc_r, pc_next_s, pc_plus4_s;
    logic [4:0]            ld_rd_r, ld_rd_next_s;

    // Decode fields
    logic [DATA_WIDTH-1:0] instr_s;
    logic [6:0]            opcode_s, funct7_s;
    logic [2:0]            funct3_s;
    logic [4:0]            rd_s, rs1_s, rs2_s;
    logic [31:0]           imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
    logic [31:0]           rs1_val_s, rs2_val_s, jalr_tgt_s;
    logic                  op_ok_s, imm_ok_s, imm_alt_s, br_taken_s;

    // Regfile write port
    logic                  rf_we_s;
    logic [4:0]            rf_waddr_s;
    logic [DATA_WIDTH-1:0] rf_wdata_s;

    // Ungated bus requests
    logic                  imem_en_s, dmem_en_s;
    logic [ADDR_WIDTH-1:0] imem_addr_s, dmem_addr_s;
    logic [3:0]            dmem_we_s;
    logic [DATA_WIDTH-1:0] dmem_wdata_s;

    // Shared ALU for OP and OP-IMM; alt selects SUB/SRA.
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3, input logic alt);
        logic [31:0] res;
        case (f3)
            3'b000:  res = alt ? (a - b) : (a + b);
            3'b001:  res = a << b[4:0];
            3'b010:  res = {31'd0, ($signed(a) < $signed(b))};
            3'b011:  res = {31'd0, (a < b)};
            3'b100:  res = a ^ b;
            3'b101:  res = alt ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  res = a | b;
            3'b111:  res = a & b;
            default: res = a + b;
        endcase
        return res;
    endfunction

    assign instr_s  = imem_rdata_i;
    assign opcode_s = instr_s[6:0];
    assign rd_s     = instr_s[11:7];
    assign funct3_s = instr_s[14:12];
    assign rs1_s    = instr_s[19:15];
    assign rs2_s    = instr_s[24:20];
    assign funct7_s = instr_s[31:25];

    assign imm_i_s = {{20{instr_s[31]}}, instr_s[31:20]};
    assign imm_s_s = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
    assign imm_b_s = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25],
                      instr_s[11:8], 1'b0};
    assign imm_u_s = {instr_s[31:12], 12'd0};
    assign imm_j_s = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20],
                      instr_s[30:21], 1'b0};

    assign pc_plus4_s = pc_r + 32'd4;
    assign jalr_tgt_s = (rs1_val_s + imm_i_s) & 32'hFFFF_FFFE;

    // Register-register ops: only funct7 0x00, or 0x20 for SUB/SRA.
    assign op_ok_s = (funct7_s == 7'h00) ||
                     ((funct7_s == 7'h20) && ((funct3_s == 3'b000) || (funct3_s == 3'b101)));
    // imm[10] picks SRAI; ADDI never subtracts.
    assign imm_alt_s = (funct3_s == 3'b101) && instr_s[30];

    jedro_1_regfile #(
        .DATA_WIDTH(DATA_WIDTH)
    ) regfile_inst (
        .clk     (clk_i),
        .rst     (rst_i),
        .we      (rf_we_s),
        .waddr   (rf_waddr_s),
        .wdata   (rf_wdata_s),
        .raddr_a (rs1_s),
        .raddr_b (rs2_s),
        .rdata_a (rs1_val_s),
        .rdata_b (rs2_val_s)
    );

    // Shift immediates must carry a legal upper field.
    always_comb begin
        imm_ok_s = 1'b1;
        case (funct3_s)
            3'b001:  imm_ok_s = (funct7_s == 7'h00);
            3'b101:  imm_ok_s = (funct7_s == 7'h00) || (funct7_s == 7'h20);
            default: imm_ok_s = 1'b1;
        endcase
    end

    // Branch condition; funct3 010/011 are undefined and never taken.
    always_comb begin
        br_taken_s = 1'b0;
        case (funct3_s)
            3'b000:  br_taken_s = (rs1_val_s == rs2_val_s);
            3'b001:  br_taken_s = (rs1_val_s != rs2_val_s);
            3'b100:  br_taken_s = ($signed(rs1_val_s) <  $signed(rs2_val_s));
            3'b101:  br_taken_s = ($signed(rs1_val_s) >= $signed(rs2_val_s));
            3'b110:  br_taken_s = (rs1_val_s <  rs2_val_s);
            3'b111:  br_taken_s = (rs1_val_s >= rs2_val_s);
            default: br_taken_s = 1'b0;
        endcase
    end

    // FSM next state, PC update, writeback and bus requests.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        ld_rd_next_s = ld_rd_r;
        rf_we_s      = 1'b0;
        rf_waddr_s   = rd_s;
        rf_wdata_s   = {DATA_WIDTH{1'b0}};
        imem_en_s    = 1'b0;
        imem_addr_s  = {ADDR_WIDTH{1'b0}};
        dmem_en_s    = 1'b0;
        dmem_we_s    = 4'h0;
        dmem_addr_s  = {ADDR_WIDTH{1'b0}};
        dmem_wdata_s = {DATA_WIDTH{1'b0}};
        case (state_r)
            ST_FETCH: begin
                imem_en_s    = 1'b1;
                imem_addr_s  = pc_r;
                state_next_s = ST_EXEC;
            end
            ST_EXEC: begin
                state_next_s = ST_FETCH;
                pc_next_s    = pc_plus4_s;
                case (opcode_s)
                    OPC_LUI: begin
                        rf_we_s    = 1'b1;
                        rf_wdata_s = imm_u_s;
                    end
                    OPC_AUIPC: begin
                        rf_we_s    = 1'b1;
                        rf_wdata_s = pc_r + imm_u_s;
                    end
                    OPC_JAL: begin
                        rf_we_s    = 1'b1;
                        rf_wdata_s = pc_plus4_s;
                        pc_next_s  = pc_r + imm_j_s;
                    end
                    OPC_JALR: begin
                        if (funct3_s == 3'b000) begin
                            rf_we_s    = 1'b1;
                            rf_wdata_s = pc_plus4_s;
                            pc_next_s  = jalr_tgt_s;
                        end else begin
                            rf_we_s = 1'b0;
                        end
                    end
                    OPC_BRANCH: begin
                        if (br_taken_s) begin
                            pc_next_s = pc_r + imm_b_s;
                        end else begin
                            pc_next_s = pc_plus4_s;
                        end
                    end
                    OPC_LOAD: begin
                        if (funct3_s == 3'b010) begin
                            dmem_en_s    = 1'b1;
                            dmem_addr_s  = rs1_val_s + imm_i_s;
                            ld_rd_next_s = rd_s;
                            pc_next_s    = pc_r;
                            state_next_s = ST_LOAD_WB;
                        end else begin
                            dmem_en_s = 1'b0;
                        end
                    end
                    OPC_STORE: begin
                        if (funct3_s == 3'b010) begin
                            dmem_en_s    = 1'b1;
                            dmem_we_s    = 4'hF;
                            dmem_addr_s  = rs1_val_s + imm_s_s;
                            dmem_wdata_s = rs2_val_s;
                        end else begin
                            dmem_en_s = 1'b0;
                        end
                    end
                    OPC_OPIMM: begin
                        if (imm_ok_s) begin
                            rf_we_s    = 1'b1;
                            rf_wdata_s = alu_f(rs1_val_s, imm_i_s, funct3_s, imm_alt_s);
                        end else begin
                            rf_we_s = 1'b0;
                        end
                    end
                    OPC_OP: begin
                        if (op_ok_s) begin
                            rf_we_s    = 1'b1;
                            rf_wdata_s = alu_f(rs1_val_s, rs2_val_s, funct3_s, funct7_s[5]);
                        end else begin
                            rf_we_s = 1'b0;
                        end
                    end
                    default: rf_we_s = 1'b0;
                endcase
            end
            ST_LOAD_WB: begin
                rf_we_s      = 1'b1;
                rf_waddr_s   = ld_rd_r;
                rf_wdata_s   = dmem_rdata_i;
                pc_next_s    = pc_plus4_s;
                state_next_s = ST_FETCH;
            end
            default: state_next_s = ST_FETCH;
        endcase
    end

    // While reset is held no request may reach either memory.
    always_comb begin
        if (rst_i) begin
            imem_en_o    = 1'b0;
            imem_addr_o  = {ADDR_WIDTH{1'b0}};
            dmem_en_o    = 1'b0;
            dmem_we_o    = 4'h0;
            dmem_addr_o  = {ADDR_WIDTH{1'b0}};
            dmem_wdata_o = {DATA_WIDTH{1'b0}};
        end else begin
            imem_en_o    = imem_en_s;
            imem_addr_o  = imem_addr_s;
            dmem_en_o    = dmem_en_s;
            dmem_we_o    = dmem_we_s;
            dmem_addr_o  = dmem_addr_s;
            dmem_wdata_o = dmem_wdata_s;
        end
    end

    // State, PC and pending load destination.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_FETCH;
            pc_r    <= BOOT_ADDR;
            ld_rd_r <= 5'd0;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            ld_rd_r <= ld_rd_next_s;
        end
    end

endmodule

// File: tb/tb_jedro_1_core.sv
`timescale 1ns/1ps

module tb_jedro_1_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        dmem_en;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = 32'd0;

    logic [31:0] rom [0:63];
    logic [31:0] load_val;

    int n_cmp = 0;
    int n_err = 0;

    // Bus monitor logs
    int          fetch_cnt   = 0;
    logic [31:0] fetch_log [0:1023];
    int          st_cnt      = 0;
    logic [31:0] st_addr  [0:15];
    logic [31:0] st_wdata [0:15];
    logic [3:0]  st_we    [0:15];
    int          dmem_cycles = 0;
    logic [31:0] ld_addr     = 32'd0;

    logic [31:0] exp_trace [0:14];

    always #5 clk = ~clk;

    jedro_1_core dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .imem_en_o    (imem_en),
        .imem_addr_o  (imem_addr),
        .imem_rdata_i (imem_rdata),
        .dmem_en_o    (dmem_en),
        .dmem_we_o    (dmem_we),
        .dmem_addr_o  (dmem_addr),
        .dmem_wdata_o (dmem_wdata),
        .dmem_rdata_i (dmem_rdata)
    );

    // Synchronous instruction ROM
    always @(posedge clk) if (imem_en) imem_rdata <= rom[imem_addr[7:2]];

    // Synchronous data port: every load returns load_val
    always @(posedge clk) if (dmem_en && (dmem_we == 4'h0)) dmem_rdata <= load_val;

    // Bus monitor
    always @(posedge clk) begin
        if (imem_en && (fetch_cnt < 1024)) begin
            fetch_log[fetch_cnt] <= imem_addr;
            fetch_cnt <= fetch_cnt + 1;
        end
        if (dmem_en) begin
            dmem_cycles <= dmem_cycles + 1;
            if ((dmem_we != 4'h0) && (st_cnt < 16)) begin
                st_addr[st_cnt]  <= dmem_addr;
                st_wdata[st_cnt] <= dmem_wdata;
                st_we[st_cnt]    <= dmem_we;
                st_cnt <= st_cnt + 1;
            end else begin
                ld_addr <= dmem_addr;
            end
        end
    end

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Assert reset and wait one cycle so the ROM can be rewritten safely.
    task automatic hold_reset();
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Check the quiet bus under reset, then release.
    task automatic release_reset();
        @(negedge clk);
        check("rst_imem_en",   {31'd0, imem_en}, 32'd0);
        check("rst_imem_addr", imem_addr,        32'd0);
        check("rst_dmem_en",   {31'd0, dmem_en}, 32'd0);
        check("rst_dmem_we",   {28'd0, dmem_we}, 32'd0);
        check("rst_dmem_addr", dmem_addr,        32'd0);
        check("rst_dmem_wdat", dmem_wdata,       32'd0);
        rst = 1'b0;
    endtask

    task automatic fill_rom();
        for (int k = 0; k < 64; k++) rom[k] = 32'h0000_006F;  // jal x0,0
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int  st_base;
        int  dc_base;
        int  fb;
        bit  found;

        rst      = 1'b1;
        load_val = 32'd0;
        exp_trace = '{32'h00, 32'h08, 32'h10, 32'h0C, 32'h18, 32'h1C, 32'h24, 32'h28,
                      32'h2C, 32'h30, 32'h34, 32'h40, 32'h44, 32'h4C, 32'h50};

        // AUIPC uses the address of the AUIPC itself
        hold_reset();
        fill_rom();
        rom[0] = enc_u(20'h00001, 5'd1, 7'h17);
        rom[1] = enc_u(20'h00002, 5'd2, 7'h17);
        rom[2] = enc_u(20'h00003, 5'd3, 7'h17);
        release_reset();
        run(32);
        check("auipc_x1", dut.regfile_inst.regfile[1], 32'h0000_1000);
        check("auipc_x2", dut.regfile_inst.regfile[2], 32'h0000_2004);
        check("auipc_x3", dut.regfile_inst.regfile[3], 32'h0000_3008);

        // LUI/ADDI and write to x0
        hold_reset();
        fill_rom();
        rom[0] = enc_u(20'hABCDE, 5'd5, 7'h37);
        rom[1] = enc_i(12'h123, 5'd5, 3'b000, 5'd5, 7'h13);
        rom[2] = enc_i(12'h005, 5'd0, 3'b000, 5'd0, 7'h13);
        release_reset();
        check("rf_cleared_x1", dut.regfile_inst.regfile[1], 32'h0);
        run(20);
        check("lui_addi_x5", dut.regfile_inst.regfile[5], 32'hABCD_E123);
        check("x0_stays_0",  dut.regfile_inst.regfile[0], 32'h0);

        // ALU with x1=-8, x2=3
        hold_reset();
        fill_rom();
        rom[0]  = enc_i(12'hFF8, 5'd0, 3'b000, 5'd1, 7'h13);
        rom[1]  = enc_i(12'h003, 5'd0, 3'b000, 5'd2, 7'h13);
        rom[2]  = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd10);          // sub
        rom[3]  = enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd11);          // sra
        rom[4]  = enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd12);          // srl
        rom[5]  = enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd13);          // sltu
        rom[6]  = enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd14);          // slt
        rom[7]  = enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd15);          // xor
        rom[8]  = enc_r(7'h00, 5'd2, 5'd2, 3'b001, 5'd16);          // sll
        rom[9]  = enc_i(12'h401, 5'd1, 3'b101, 5'd17, 7'h13);       // srai 1
        rom[10] = enc_i(12'h00F, 5'd1, 3'b111, 5'd18, 7'h13);       // andi
        rom[11] = enc_i(12'hFF0, 5'd2, 3'b110, 5'd19, 7'h13);       // ori -16
        rom[12] = enc_i(12'hFF9, 5'd1, 3'b010, 5'd20, 7'h13);       // slti -7
        rom[13] = enc_i(12'hFFF, 5'd2, 3'b011, 5'd21, 7'h13);       // sltiu -1
        rom[14] = enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd22);          // mul: NOP
        rom[15] = 32'hFFFF_FFFF;                                     // unknown
        rom[16] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd24);          // add
        rom[17] = enc_i(12'h001, 5'd0, 3'b000, 5'd23, 7'h13);
        release_reset();
        run(50);
        check("sub",   dut.regfile_inst.regfile[10], 32'hFFFF_FFF5);
        check("sra",   dut.regfile_inst.regfile[11], 32'hFFFF_FFFF);
        check("srl",   dut.regfile_inst.regfile[12], 32'h1FFF_FFFF);
        check("sltu",  dut.regfile_inst.regfile[13], 32'h0);
        check("slt",   dut.regfile_inst.regfile[14], 32'h1);
        check("xor",   dut.regfile_inst.regfile[15], 32'hFFFF_FFFB);
        check("sll",   dut.regfile_inst.regfile[16], 32'h18);
        check("srai",  dut.regfile_inst.regfile[17], 32'hFFFF_FFFC);
        check("andi",  dut.regfile_inst.regfile[18], 32'h8);
        check("ori",   dut.regfile_inst.regfile[19], 32'hFFFF_FFF3);
        check("slti",  dut.regfile_inst.regfile[20], 32'h1);
        check("sltiu", dut.regfile_inst.regfile[21], 32'h1);
        check("bad_funct_nop", dut.regfile_inst.regfile[22], 32'h0);
        check("add",   dut.regfile_inst.regfile[24], 32'hFFFF_FFFB);
        check("after_unknown", dut.regfile_inst.regfile[23], 32'h1);

        // LW / SW, including a misaligned store address
        hold_reset();
        fill_rom();
        rom[0] = enc_u(20'hABCDE, 5'd5, 7'h37);
        rom[1] = enc_i(12'h123, 5'd5, 3'b000, 5'd5, 7'h13);
        rom[2] = enc_i(12'h008, 5'd0, 3'b010, 5'd6, 7'h03);         // lw x6,8(x0)
        rom[3] = enc_s(12'h008, 5'd5, 5'd0);                          // sw x5,8(x0)
        rom[4] = enc_s(12'h00D, 5'd5, 5'd0);                          // sw x5,13(x0)
        load_val = 32'h1234_5678;
        st_base  = st_cnt;
        dc_base  = dmem_cycles;
        release_reset();
        run(30);
        check("lw_x6",        dut.regfile_inst.regfile[6], 32'h1234_5678);
        check("lw_addr",      ld_addr, 32'h8);
        check("store_count",  st_cnt - st_base, 32'd2);
        check("dmem_cycles",  dmem_cycles - dc_base, 32'd3);
        check("sw_we",        {28'd0, st_we[st_base]}, 32'hF);
        check("sw_addr",      st_addr[st_base], 32'h8);
        check("sw_wdata",     st_wdata[st_base], 32'hABCD_E123);
        check("sw_misalign",  st_addr[st_base + 1], 32'hD);

        // Branches and jumps
        hold_reset();
        fill_rom();
        rom[0]  = enc_b(13'd8, 5'd0, 5'd0, 3'b000);                  // beq +8
        rom[1]  = enc_i(12'h001, 5'd0, 3'b000, 5'd8, 7'h13);
        rom[2]  = enc_j(21'd8, 5'd0);                                 // -> 0x10
        rom[3]  = enc_j(21'd12, 5'd0);                                // -> 0x18
        rom[4]  = enc_j(21'h1FFFFC, 5'd1);                            // jal x1,-4
        rom[5]  = enc_i(12'h002, 5'd0, 3'b000, 5'd8, 7'h13);
        rom[6]  = enc_i(12'hFFF, 5'd0, 3'b000, 5'd10, 7'h13);        // x10=-1
        rom[7]  = enc_b(13'd8, 5'd10, 5'd0, 3'b110);                 // bltu taken
        rom[8]  = enc_i(12'h003, 5'd0, 3'b000, 5'd8, 7'h13);
        rom[9]  = enc_b(13'd8, 5'd10, 5'd0, 3'b100);                 // blt not
        rom[10] = enc_i(12'h005, 5'd0, 3'b000, 5'd11, 7'h13);
        rom[11] = enc_b(13'd8, 5'd0, 5'd0, 3'b001);                  // bne not
        rom[12] = enc_i(12'h006, 5'd0, 3'b000, 5'd12, 7'h13);
        rom[13] = enc_i(12'h041, 5'd0, 3'b000, 5'd14, 7'h67);        // jalr -> 0x40
        rom[14] = enc_i(12'h004, 5'd0, 3'b000, 5'd8, 7'h13);
        rom[15] = enc_i(12'h005, 5'd0, 3'b000, 5'd8, 7'h13);
        rom[16] = enc_b(13'd8, 5'd0, 5'd10, 3'b101);                 // bge not
        rom[17] = enc_b(13'd8, 5'd0, 5'd10, 3'b111);                 // bgeu taken
        rom[18] = enc_i(12'h006, 5'd0, 3'b000, 5'd8, 7'h13);
        rom[19] = enc_i(12'h009, 5'd0, 3'b000, 5'd15, 7'h13);
        release_reset();
        fb = fetch_cnt;
        run(60);
        check("jal_link_x1",  dut.regfile_inst.regfile[1],  32'h14);
        check("skipped_x8",   dut.regfile_inst.regfile[8],  32'h0);
        check("blt_fall_x11", dut.regfile_inst.regfile[11], 32'h5);
        check("bne_fall_x12", dut.regfile_inst.regfile[12], 32'h6);
        check("jalr_link",    dut.regfile_inst.regfile[14], 32'h38);
        check("bgeu_tgt_x15", dut.regfile_inst.regfile[15], 32'h9);
        for (int k = 0; k < 15; k++) begin
            check($sformatf("fetch_trace_%0d", k), fetch_log[fb + k], exp_trace[k]);
        end

        // Reset during LOAD_WB abandons the load
        hold_reset();
        fill_rom();
        rom[0] = enc_i(12'h001, 5'd0, 3'b000, 5'd3, 7'h13);
        rom[1] = enc_i(12'h008, 5'd0, 3'b010, 5'd7, 7'h03);          // lw x7,8(x0)
        load_val = 32'h1234_5678;
        release_reset();
        found = 1'b0;
        for (int k = 0; (k < 20) && !found; k++) begin
            @(negedge clk);
            if (dmem_en) found = 1'b1;
        end
        check("lw_issue_seen", {31'd0, found}, 32'd1);
        @(negedge clk);
        check("wb_dmem_idle", {31'd0, dmem_en}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_x7",      dut.regfile_inst.regfile[7], 32'h0);
        check("abort_x3_clr",  dut.regfile_inst.regfile[3], 32'h0);
        check("abort_imem_en", {31'd0, imem_en}, 32'd0);
        check("abort_dmem_en", {31'd0, dmem_en}, 32'd0);
        rst = 1'b0;
        #1;
        check("boot_fetch_en",   {31'd0, imem_en}, 32'd1);
        check("boot_fetch_addr", imem_addr, 32'h0);
        run(12);
        check("restart_x7", dut.regfile_inst.regfile[7], 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
